// File: rtl/hpu_if_fetch_ctrl_if.sv
// ============================================================================
// hpu_if_fetch_ctrl_if : icache request/response and ibuf write bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hpu_if_fetch_ctrl_if;
  logic             ic_req_vld_o;
  logic [31:0]      ic_req_addr_o;
  logic             ic_req_rdy_i;
  logic             ic_rsp_vld_i;
  logic [63:0]      ic_rsp_data_i;
  logic             ibuf_afull_i;
  logic [1:0][31:0] ibuf_inst_o;
  logic [1:0][31:0] ibuf_pc_o;
  logic [1:0]       ibuf_inst_en_o;

  modport master (
    output ic_req_vld_o, ic_req_addr_o, ibuf_inst_o, ibuf_pc_o, ibuf_inst_en_o,
    input  ic_req_rdy_i, ic_rsp_vld_i, ic_rsp_data_i, ibuf_afull_i
  );

  modport slave (
    input  ic_req_vld_o, ic_req_addr_o, ibuf_inst_o, ibuf_pc_o, ibuf_inst_en_o,
    output ic_req_rdy_i, ic_rsp_vld_i, ic_rsp_data_i, ibuf_afull_i
  );
endinterface

`default_nettype wire

// File: rtl/hpu_if_fetch_ctrl.sv
// ============================================================================
// hpu_if_fetch_ctrl : fetch PC sequencing, icache request issue, redirect drain
// Revision: 1.0
// ============================================================================
`default_nettype none

module hpu_if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fetch_en_i,
  input  logic                       redirect_en_i,
  input  logic [31:0]                redirect_pc_i,
  hpu_if_fetch_ctrl_if.master        bus
);

  localparam int unsigned c_CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned c_PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTST);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:2]          r_fetch_pc;
  logic [c_CNT_W-1:0]   r_outst_cnt;
  logic [c_CNT_W-1:0]   r_drop_cnt;
  logic [c_CNT_W-1:0]   w_outst_nxt;
  logic [c_CNT_W-1:0]   w_drop_nxt;
  logic                 r_first;
  logic [31:3]          r_fifo_line [MAX_OUTST];
  logic [MAX_OUTST-1:0] r_fifo_odd;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [1:0][31:0]     r_ibuf_inst;
  logic [1:0][31:0]     r_ibuf_pc;
  logic [1:0]           r_ibuf_en;
  logic                 w_req_vld;
  logic                 w_accept;
  logic                 w_rsp;
  logic                 w_fwd;
  logic                 w_unused;

  // Responses with nothing outstanding are illegal and simply ignored.
  assign w_rsp    = bus.ic_rsp_vld_i && (r_outst_cnt != '0);
  assign w_fwd    = w_rsp && !redirect_en_i && (r_drop_cnt == '0);
  assign w_accept = w_req_vld && bus.ic_req_rdy_i;
  assign w_unused = &{1'b0, redirect_pc_i[1:0]};

  always_comb begin
    w_req_vld   = 1'b0;
    w_outst_nxt = r_outst_cnt;
    w_drop_nxt  = r_drop_cnt;
    w_state_nxt = r_state;

    w_req_vld = (r_state == ST_FETCH) && fetch_en_i && !bus.ibuf_afull_i &&
                (r_outst_cnt < c_MAX_CNT) && !redirect_en_i && (r_drop_cnt == '0);

    if (w_req_vld && bus.ic_req_rdy_i && !w_rsp) begin
      w_outst_nxt = r_outst_cnt + c_CNT_ONE;
    end else if (!(w_req_vld && bus.ic_req_rdy_i) && w_rsp) begin
      w_outst_nxt = r_outst_cnt - c_CNT_ONE;
    end

    // Everything still in flight after a redirect belongs to the old stream.
    if (redirect_en_i) begin
      w_drop_nxt = w_outst_nxt;
    end else if (w_rsp && (r_drop_cnt != '0)) begin
      w_drop_nxt = r_drop_cnt - c_CNT_ONE;
    end

    case (r_state)
      ST_IDLE:  if (fetch_en_i) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_FETCH;
      ST_DRAIN: if (r_drop_cnt == '0) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (redirect_en_i) begin
      w_state_nxt = (w_drop_nxt != '0) ? ST_DRAIN : ST_FETCH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc  <= RESET_PC[31:2];
      r_outst_cnt <= '0;
      r_drop_cnt  <= '0;
      r_first     <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_odd  <= '0;
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        r_fifo_line[i] <= '0;
      end
      r_ibuf_inst <= '0;
      r_ibuf_pc   <= '0;
      r_ibuf_en   <= 2'b00;
    end else begin
      r_outst_cnt <= w_outst_nxt;
      r_drop_cnt  <= w_drop_nxt;

      if (redirect_en_i) begin
        r_fetch_pc <= redirect_pc_i[31:2];
        r_first    <= 1'b1;
      end else if (w_accept) begin
        r_fetch_pc <= {r_fetch_pc[31:3] + 29'd1, 1'b0};
        r_first    <= 1'b0;
      end

      if (w_accept) begin
        r_fifo_line[r_wr_ptr] <= r_fetch_pc[31:3];
        r_fifo_odd[r_wr_ptr]  <= r_first && r_fetch_pc[2];
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
      end

      // Dropped responses still retire their FIFO entry to keep it in order.
      if (w_rsp) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;
      end

      if (w_fwd) begin
        r_ibuf_inst[0] <= bus.ic_rsp_data_i[31:0];
        r_ibuf_inst[1] <= bus.ic_rsp_data_i[63:32];
        r_ibuf_pc[0]   <= {r_fifo_line[r_rd_ptr], 3'b000};
        r_ibuf_pc[1]   <= {r_fifo_line[r_rd_ptr], 3'b100};
        r_ibuf_en      <= r_fifo_odd[r_rd_ptr] ? 2'b10 : 2'b11;
      end else begin
        r_ibuf_en      <= 2'b00;
      end
    end
  end

  assign bus.ic_req_vld_o   = w_req_vld;
  assign bus.ic_req_addr_o  = {r_fetch_pc[31:3], 3'b000};
  assign bus.ibuf_inst_o    = r_ibuf_inst;
  assign bus.ibuf_pc_o      = r_ibuf_pc;
  assign bus.ibuf_inst_en_o = r_ibuf_en;

  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(bus.ic_rsp_vld_i && (r_outst_cnt == '0)));

endmodule

`default_nettype wire

// File: tb/tb_hpu_if_fetch_ctrl.sv
// ============================================================================
// tb_hpu_if_fetch_ctrl : directed table, corner sequences and random vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hpu_if_fetch_ctrl;

  localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
  localparam int          c_MAX      = 2;
  localparam int          c_NTBL     = 20;
  localparam int          c_NRAND    = 3000;

  logic        clk_i         = 1'b0;
  logic        rst_i         = 1'b0;
  logic        fetch_en_i    = 1'b0;
  logic        redirect_en_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  hpu_if_fetch_ctrl_if bus ();

  hpu_if_fetch_ctrl #(
    .RESET_PC  (c_RESET_PC),
    .MAX_OUTST (c_MAX)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .redirect_en_i (redirect_en_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [63:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        vld;
    logic [31:0] addr;
    logic [1:0]  en;
    logic [31:0] pc0;
    logic [63:0] inst;
  } vec_t;

  typedef struct {
    logic [31:0] line;
    logic        odd;
    int          gen;
    logic [63:0] data;
    int          acc;
  } flight_t;

  vec_t tbl [c_NTBL];

  function automatic logic [63:0] d(input int k);
    return {32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
  endfunction

  function automatic vec_t v(input logic rdy, input logic rsp, input logic [63:0] data,
                             input logic redir, input logic [31:0] rpc, input logic vld,
                             input logic [31:0] addr, input logic [1:0] en,
                             input logic [31:0] pc0, input logic [63:0] inst);
    vec_t r;
    r.rdy = rdy; r.rsp = rsp; r.data = data; r.redir = redir; r.rpc = rpc;
    r.vld = vld; r.addr = addr; r.en = en; r.pc0 = pc0; r.inst = inst;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_req(input string nm, input logic vld, input logic [31:0] addr);
    chk({nm, ".vld"}, 64'(bus.ic_req_vld_o), 64'(vld));
    chk({nm, ".addr"}, 64'(bus.ic_req_addr_o), 64'(addr));
  endtask

  task automatic chk_ibuf(input string nm, input logic [1:0] en, input logic [31:0] pc0,
                          input logic [63:0] inst);
    chk({nm, ".en"}, 64'(bus.ibuf_inst_en_o), 64'(en));
    if (en != 2'b00) begin
      chk({nm, ".pc0"}, 64'(bus.ibuf_pc_o[0]), 64'(pc0));
      chk({nm, ".pc1"}, 64'(bus.ibuf_pc_o[1]), 64'(pc0 + 32'd4));
      chk({nm, ".inst"}, {bus.ibuf_inst_o[1], bus.ibuf_inst_o[0]}, inst);
    end
  endtask

  // Inputs change on the falling edge; outputs are looked at 1 ns later.
  task automatic drive(input logic fe, input logic af, input logic rdy, input logic rsp,
                       input logic [63:0] data, input logic redir, input logic [31:0] rpc);
    @(negedge clk_i);
    fetch_en_i        = fe;
    bus.ibuf_afull_i  = af;
    bus.ic_req_rdy_i  = rdy;
    bus.ic_rsp_vld_i  = rsp;
    bus.ic_rsp_data_i = data;
    redirect_en_i     = redir;
    redirect_pc_i     = rpc;
    #1;
  endtask

  // Reference model state
  flight_t     q[$];
  logic [31:0] m_pc;
  logic        m_first;
  int          m_gen;
  logic        m_started;
  logic        m_gap;
  logic [1:0]  m_en;
  logic [31:0] m_pc0;
  logic [63:0] m_inst;

  task automatic model_reset();
    q.delete();
    m_pc = c_RESET_PC; m_first = 1'b1; m_gen = 0; m_started = 1'b0; m_gap = 1'b0;
    m_en = 2'b00; m_pc0 = '0; m_inst = '0;
  endtask

  task automatic run_random();
    for (int cyc = 0; cyc < c_NRAND; cyc++) begin
      logic fe, af, rdy, redir, rsp, exp_vld;
      logic [31:0] rpc, line;
      logic [63:0] data;
      int stale, stale_after;
      flight_t h;
      fe    = ($urandom_range(0, 9) != 0);
      af    = ($urandom_range(0, 6) == 0);
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 39) == 0);
      rpc   = $urandom;
      rsp   = (q.size() > 0) && (q[0].acc < cyc) && ($urandom_range(0, 9) < 6);
      data  = rsp ? q[0].data : 64'h0;
      stale = 0;
      foreach (q[k]) if (q[k].gen != m_gen) stale++;
      line    = {m_pc[31:3], 3'b000};
      exp_vld = m_started && !m_gap && (stale == 0) && fe && !af &&
                (q.size() < c_MAX) && !redir;

      drive(fe, af, rdy, rsp, data, redir, rpc);
      chk_req("rnd", exp_vld, line);
      chk_ibuf("rnd", m_en, m_pc0, m_inst);

      m_en = 2'b00;
      if (rsp) begin
        h = q.pop_front();
        if (!redir && (h.gen == m_gen)) begin
          m_en = h.odd ? 2'b10 : 2'b11; m_pc0 = h.line; m_inst = h.data;
        end
      end
      if (exp_vld && rdy) begin
        q.push_back('{line, m_first && m_pc[2], m_gen, {$urandom, $urandom}, cyc});
        m_pc    = line + 32'd8;
        m_first = 1'b0;
      end
      stale_after = 0;
      foreach (q[k]) if (q[k].gen != m_gen) stale_after++;
      if (redir) begin
        m_pc = {rpc[31:2], 2'b00}; m_first = 1'b1; m_gen++; m_started = 1'b1; m_gap = 1'b0;
      end else begin
        m_gap = (stale > 0) && (stale_after == 0);
        if (fe) m_started = 1'b1;
      end
    end
  endtask

  initial begin
    bus.ic_req_rdy_i = 1'b0; bus.ic_rsp_vld_i = 1'b0; bus.ic_rsp_data_i = '0;
    bus.ibuf_afull_i = 1'b0;

    //            rdy rsp data  rdr rpc        vld addr          en     pc0           inst
    tbl[0]  = v(1, 0, 0,     0, 0,          0, 32'h8000_0000, 2'b00, 0,            0);
    tbl[1]  = v(1, 0, 0,     0, 0,          1, 32'h8000_0000, 2'b00, 0,            0);
    tbl[2]  = v(1, 0, 0,     0, 0,          1, 32'h8000_0008, 2'b00, 0,            0);
    tbl[3]  = v(1, 1, d(0),  0, 0,          0, 32'h8000_0010, 2'b00, 0,            0);
    tbl[4]  = v(1, 1, d(1),  0, 0,          1, 32'h8000_0010, 2'b11, 32'h8000_0000, d(0));
    tbl[5]  = v(1, 0, 0,     0, 0,          1, 32'h8000_0018, 2'b11, 32'h8000_0008, d(1));
    tbl[6]  = v(1, 0, 0,     1, 32'h1004,   0, 32'h8000_0020, 2'b00, 0,            0);
    tbl[7]  = v(1, 1, d(2),  0, 0,          0, 32'h0000_1000, 2'b00, 0,            0);
    tbl[8]  = v(1, 1, d(3),  0, 0,          0, 32'h0000_1000, 2'b00, 0,            0);
    tbl[9]  = v(1, 0, 0,     0, 0,          0, 32'h0000_1000, 2'b00, 0,            0);
    tbl[10] = v(1, 0, 0,     0, 0,          1, 32'h0000_1000, 2'b00, 0,            0);
    tbl[11] = v(1, 0, 0,     0, 0,          1, 32'h0000_1008, 2'b00, 0,            0);
    tbl[12] = v(1, 1, d(4),  0, 0,          0, 32'h0000_1010, 2'b00, 0,            0);
    tbl[13] = v(1, 0, 0,     0, 0,          1, 32'h0000_1010, 2'b10, 32'h0000_1000, d(4));
    tbl[14] = v(1, 1, d(5),  1, 32'h2000,   0, 32'h0000_1018, 2'b00, 0,            0);
    tbl[15] = v(1, 1, d(6),  0, 0,          0, 32'h0000_2000, 2'b00, 0,            0);
    tbl[16] = v(1, 0, 0,     0, 0,          0, 32'h0000_2000, 2'b00, 0,            0);
    tbl[17] = v(1, 0, 0,     0, 0,          1, 32'h0000_2000, 2'b00, 0,            0);
    tbl[18] = v(0, 1, d(7),  0, 0,          1, 32'h0000_2008, 2'b00, 0,            0);
    tbl[19] = v(0, 0, 0,     0, 0,          1, 32'h0000_2008, 2'b11, 32'h0000_2000, d(7));

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk_req("reset", 1'b0, c_RESET_PC);
    chk_ibuf("reset", 2'b00, 0, 0);
    chk("reset.pc0", 64'(bus.ibuf_pc_o[0]), 64'h0);
    chk("reset.inst", {bus.ibuf_inst_o[1], bus.ibuf_inst_o[0]}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < c_NTBL; i++) begin
      drive(1'b1, 1'b0, tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].redir, tbl[i].rpc);
      chk_req($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].addr);
      chk_ibuf($sformatf("tbl%0d", i), tbl[i].en, tbl[i].pc0, tbl[i].inst);
    end

    // afull blocks requests but not the outstanding response
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_req("afull.pre", 1'b1, 32'h2008);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, i == 1, d(8), 0, 0);
      chk_req($sformatf("afull%0d", i), 1'b0, 32'h2010);
      if (i == 2) chk_ibuf("afull.fwd", 2'b11, 32'h2008, d(8));
    end

    // Stalled icache: request held stable for 4 cycles
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk_req($sformatf("stall%0d", i), 1'b1, 32'h2010);
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_req("stall.acc", 1'b1, 32'h2010);
    drive(1, 0, 0, 1, d(9), 0, 0);
    chk_req("stall.next", 1'b1, 32'h2018);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_ibuf("stall.fwd", 2'b11, 32'h2010, d(9));

    // Address wrap at the top of the 32-bit space
    drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    chk_req("wrap.redir", 1'b0, 32'h2018);
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_req("wrap.top", 1'b1, 32'hFFFF_FFF8);
    drive(1, 0, 0, 1, d(10), 0, 0);
    chk_req("wrap.zero", 1'b1, 32'h0000_0000);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_ibuf("wrap.fwd", 2'b11, 32'hFFFF_FFF8, d(10));

    // Redirect target low bits ignored; odd first slot suppressed
    drive(1, 0, 0, 0, 0, 1, 32'h0000_3007);
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_req("odd.req", 1'b1, 32'h3000);
    drive(1, 0, 0, 1, d(11), 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_ibuf("odd.fwd", 2'b10, 32'h3000, d(11));
    chk_req("odd.next", 1'b1, 32'h3008);

    // Asynchronous reset with a request still in flight
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk_req("areset", 1'b0, c_RESET_PC);
    chk("areset.en", 64'(bus.ibuf_inst_en_o), 64'h0);
    chk("areset.pc0", 64'(bus.ibuf_pc_o[0]), 64'h0);
    fetch_en_i = 1'b0; redirect_en_i = 1'b0; bus.ic_req_rdy_i = 1'b0;
    bus.ic_rsp_vld_i = 1'b0; bus.ibuf_afull_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    model_reset();
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
